// File: rtl/digit_serial_adder_pkg.sv
// Shared definitions for the digit-serial adder: operation modes, FSM encoding
// and the elaboration-time width check.
package gf_adder_pkg;

  localparam logic [1:0] MODE_ADD   = 2'b00;
  localparam logic [1:0] MODE_SUB   = 2'b01;
  localparam logic [1:0] MODE_GFADD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // True when the digit width is legal and evenly splits the operand.
  function automatic bit width_ok(input int data_width, input int digit_width);
    return (digit_width >= 1) && (digit_width <= data_width) &&
           ((data_width % digit_width) == 0);
  endfunction

endpackage

// File: rtl/digit_serial_adder_if.sv
// Request/response handshake bundle between operand producers, the adder and
// its result consumer.
interface digit_serial_adder_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            in_mode;
  logic [DATA_WIDTH-1:0] in_sum_a;
  logic [DATA_WIDTH-1:0] in_sum_b;
  logic                  in_carry;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_sum_result;
  logic                  out_carry;
  logic                  out_overflow;

  modport slave (
    input  in_valid, in_mode, in_sum_a, in_sum_b, in_carry, out_ready,
    output in_ready, out_valid, out_sum_result, out_carry, out_overflow
  );

  modport master (
    output in_valid, in_mode, in_sum_a, in_sum_b, in_carry, out_ready,
    input  in_ready, out_valid, out_sum_result, out_carry, out_overflow
  );
endinterface

// File: rtl/digit_serial_adder_digit.sv
// One digit slice: binary add with carry, or carry-free XOR in GF(2^m) mode.
module digit_adder #(
  parameter int DIGIT_WIDTH = 4
) (
  input  logic [DIGIT_WIDTH-1:0] a,
  input  logic [DIGIT_WIDTH-1:0] b,
  input  logic                   cin,
  input  logic                   gf_mode,
  output logic [DIGIT_WIDTH-1:0] sum,
  output logic                   cout
);
  logic [DIGIT_WIDTH:0] full;

  assign full = {1'b0, a} + {1'b0, b} + (DIGIT_WIDTH+1)'(cin);
  assign sum  = gf_mode ? (a ^ b) : full[DIGIT_WIDTH-1:0];
  assign cout = gf_mode ? 1'b0 : full[DIGIT_WIDTH];
endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle adder: consumes one DIGIT_WIDTH slice per clock, LSD first,
// with valid/ready handshakes on request and result sides.
module digit_serial_adder
  import gf_adder_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DIGIT_WIDTH = 4
) (
  input logic               clk,
  input logic               reset,
  digit_serial_adder_if.slave bus
);
  localparam int N  = DATA_WIDTH / DIGIT_WIDTH;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (!width_ok(DATA_WIDTH, DIGIT_WIDTH)) begin : g_bad_width
    $fatal(1, "digit_serial_adder: DIGIT_WIDTH must divide DATA_WIDTH");
  end

  state_t                state, state_nx;
  logic                  accept, last, in_ready, out_valid;
  logic [DATA_WIDTH-1:0] a_sh, b_sh, res_sh, res_next;
  logic                  carry, gf, msb_a, msb_b;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] sum_q;
  logic                  carry_q, ovf_q;
  logic [DIGIT_WIDTH-1:0] dsum;
  logic                  dcout;

  digit_adder #(.DIGIT_WIDTH(DIGIT_WIDTH)) u_digit (
    .a       (a_sh[DIGIT_WIDTH-1:0]),
    .b       (b_sh[DIGIT_WIDTH-1:0]),
    .cin     (carry),
    .gf_mode (gf),
    .sum     (dsum),
    .cout    (dcout)
  );

  // New digit enters at the top; after N shifts the LSD has reached bit 0.
  assign res_next = (res_sh >> DIGIT_WIDTH) |
                    (DATA_WIDTH'(dsum) << (DATA_WIDTH - DIGIT_WIDTH));
  assign last     = (cnt == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          accept   = 1'b1;
          state_nx = ST_RUN;
        end
      end
      ST_RUN: begin
        if (last) state_nx = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        in_ready  = bus.out_ready;
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            accept   = 1'b1;
            state_nx = ST_RUN;
          end else begin
            state_nx = ST_IDLE;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh    <= '0;
      b_sh    <= '0;
      res_sh  <= '0;
      carry   <= 1'b0;
      gf      <= 1'b0;
      msb_a   <= 1'b0;
      msb_b   <= 1'b0;
      cnt     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      // Subtraction runs as A + ~B + 1 through the same adder.
      a_sh  <= bus.in_sum_a;
      b_sh  <= (bus.in_mode == MODE_SUB) ? ~bus.in_sum_b : bus.in_sum_b;
      gf    <= (bus.in_mode == MODE_GFADD);
      msb_a <= bus.in_sum_a[DATA_WIDTH-1];
      msb_b <= (bus.in_mode == MODE_SUB) ? ~bus.in_sum_b[DATA_WIDTH-1]
                                         : bus.in_sum_b[DATA_WIDTH-1];
      case (bus.in_mode)
        MODE_SUB:   carry <= 1'b1;
        MODE_GFADD: carry <= 1'b0;
        default:    carry <= bus.in_carry;
      endcase
      cnt <= '0;
    end else if (state == ST_RUN) begin
      a_sh   <= a_sh >> DIGIT_WIDTH;
      b_sh   <= b_sh >> DIGIT_WIDTH;
      res_sh <= res_next;
      carry  <= gf ? 1'b0 : dcout;
      cnt    <= cnt + CW'(1);
      if (last) begin
        sum_q   <= res_next;
        carry_q <= gf ? 1'b0 : dcout;
        ovf_q   <= ~gf & (msb_a == msb_b) & (res_next[DATA_WIDTH-1] != msb_a);
      end
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = out_valid;
  assign bus.out_sum_result = sum_q;
  assign bus.out_carry      = carry_q;
  assign bus.out_overflow   = ovf_q;
endmodule
